// File: rtl/blur_pkg.sv
// Shared types and constants for the blur stage front end.
package blur_pkg;

    localparam int unsigned STRIP_W = 16;
    localparam int unsigned HALO    = 2;
    localparam int unsigned WIN_W   = 20;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StReady,
        StDrain
    } feeder_state_e;

    // col_h is the image column plus HALO, so the leftmost halo pixels stay non-negative.
    function automatic logic [31:0] clamp_col(input logic [31:0] col_h, input logic [31:0] width);
        if (col_h < 32'(HALO)) begin
            return 32'd0;
        end else if (col_h - 32'(HALO) >= width) begin
            return width - 32'd1;
        end else begin
            return col_h - 32'(HALO);
        end
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Up counter with synchronous clear that wraps from rollover_val_i-1 back to 0.
module flex_counter #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear_i,
    input  logic                    count_enable_i,
    input  logic [NUM_CNT_BITS-1:0] rollover_val_i,
    output logic [NUM_CNT_BITS-1:0] count_o,
    output logic                    rollover_flag_o
);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;

    // Flag marks the final index before the wrap.
    always_comb begin
        rollover_flag_o = (count_q == rollover_val_i - NUM_CNT_BITS'(1));
        count_d         = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_enable_i) begin
            count_d = rollover_flag_o ? '0 : count_q + NUM_CNT_BITS'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/blur_row_feeder.sv
// Fetches 20-pixel row windows strip by strip and hands them to the blur controller,
// prefetching the next row into a shadow buffer while the current one is filtered.
module blur_row_feeder
    import blur_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 320,
    parameter int unsigned IMG_HEIGHT = 240,
    parameter int unsigned ADDR_W     = 18
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      img_base,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [7:0]             mem_rdata,
    input  logic                   mem_ack,
    output logic                   anchor_moving,
    output logic [15:0]            anchor_x,
    output logic [15:0]            anchor_y,
    output logic [WIN_W-1:0][7:0]  blur_in,
    input  logic                   blur_final
);

    localparam logic [15:0] LastX   = 16'(IMG_WIDTH - STRIP_W);
    localparam logic [15:0] Height  = 16'(IMG_HEIGHT);
    localparam logic [15:0] LastY   = 16'(IMG_HEIGHT + 2);

    feeder_state_e         state_q;
    logic [ADDR_W-1:0]     base_q;
    logic [15:0]           x0_q;
    logic [15:0]           y_q;
    logic [WIN_W-1:0][7:0] shadow_q;

    logic [4:0]  idx;
    logic        idx_last;
    logic        cnt_clear;
    logic        cnt_en;
    logic        launch;
    logic        last_row;
    logic        last_frame;
    logic        next_flush;
    logic [15:0] x0_next;
    logic [15:0] y_next;
    logic [31:0] row_w;
    logic [31:0] col_c;

    // Launch decision and the (x0, y) step that follows it.
    always_comb begin
        launch     = (state_q == StReady) && blur_final && !anchor_moving;
        last_row   = (y_q == LastY);
        last_frame = last_row && (x0_q == LastX);
        y_next     = last_row ? 16'd1 : y_q + 16'd1;
        x0_next    = last_row ? x0_q + 16'(STRIP_W) : x0_q;
        next_flush = (y_next > Height);
        cnt_clear  = ((state_q == StIdle) && start) || (launch && !last_frame && !next_flush);
        cnt_en     = (state_q == StFetch) && mem_ack;
    end

    flex_counter #(
        .NUM_CNT_BITS(5)
    ) u_idx_cnt (
        .clk             (clk),
        .n_rst           (n_rst),
        .clear_i         (cnt_clear),
        .count_enable_i  (cnt_en),
        .rollover_val_i  (5'(WIN_W)),
        .count_o         (idx),
        .rollover_flag_o (idx_last)
    );

    // Read address: pending row (y-1), window column clamped to the image.
    always_comb begin
        row_w    = 32'(y_q) - 32'd1;
        col_c    = clamp_col(32'(x0_q) + 32'(idx), 32'(IMG_WIDTH));
        mem_req  = (state_q == StFetch);
        mem_addr = '0;
        if (state_q == StFetch) begin
            mem_addr = ADDR_W'(32'(base_q) + row_w * 32'(IMG_WIDTH) + col_c);
        end
    end

    // Feeder FSM with registered handshake and window outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= StIdle;
            base_q        <= '0;
            x0_q          <= '0;
            y_q           <= '0;
            shadow_q      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            anchor_moving <= 1'b0;
            anchor_x      <= '0;
            anchor_y      <= '0;
            blur_in       <= '0;
        end else begin
            done          <= 1'b0;
            anchor_moving <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        base_q  <= img_base;
                        x0_q    <= '0;
                        y_q     <= 16'd1;
                        busy    <= 1'b1;
                        state_q <= StFetch;
                    end
                end
                StFetch: begin
                    if (mem_ack) begin
                        shadow_q[idx] <= mem_rdata;
                        if (idx_last) begin
                            state_q <= StReady;
                        end
                    end
                end
                StReady: begin
                    if (launch) begin
                        anchor_moving <= 1'b1;
                        blur_in       <= shadow_q;
                        anchor_x      <= x0_q;
                        anchor_y      <= y_q;
                        x0_q          <= x0_next;
                        y_q           <= y_next;
                        if (last_frame) begin
                            state_q <= StDrain;
                        end else if (next_flush) begin
                            // Flush rows reuse the shadow contents (last image row).
                            state_q <= StReady;
                        end else begin
                            state_q <= StFetch;
                        end
                    end
                end
                StDrain: begin
                    if (blur_final && !anchor_moving) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
